fetch_pc: RTL
=============

FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 8, SHALL be the maximum number of REQ-state cycles allowed without mem_ack (range 1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 jmp  input  1  SHALL be the take-jump decision from jump control.
REQ-006 incr  input  1  SHALL be the sequential-advance decision from jump control.
REQ-007 target  input  16  SHALL be the jump destination address.
REQ-008 step_en  input  1  SHALL indicate that execute consumes the held instruction this cycle.
REQ-009 mem_ack  input  1  SHALL indicate that mem_data is valid for the current request.
REQ-010 mem_data  input  16  SHALL be the instruction word from memory.
REQ-011 mem_req  output  1  SHALL be the fetch request to memory.
REQ-012 mem_addr  output  16  SHALL be the fetch address, always equal to pc.
REQ-013 pc  output  16  SHALL be the address of the current or in-flight instruction.
REQ-014 instr  output  16  SHALL be the latched instruction word.
REQ-015 instr_valid  output  1  SHALL be high when instr is held for execute.
REQ-016 fault  output  1  SHALL be the sticky fetch-timeout indication.

Function
REQ-017 FSM states SHALL be IDLE, REQ, HOLD and FAULT.
REQ-018 IDLE SHALL go to REQ unconditionally after one cycle.
REQ-019 In REQ: mem_req=1; on mem_ack, instr<=mem_data and the FSM SHALL go to HOLD.
REQ-020 In HOLD: instr_valid=1, mem_req=0; without step_en, instr and pc SHALL hold indefinitely.
REQ-021 HOLD with step_en: if jmp, pc<=target; else if incr, pc<=pc+1; else pc unchanged (re-fetch); FSM SHALL go to REQ.
REQ-022 jmp SHALL take priority when jmp and incr are both high.
REQ-023 jmp, incr and target SHALL be ignored outside HOLD or when step_en=0.
REQ-024 pc+1 SHALL be modulo 2^16 (16'hFFFF -> 16'h0000); no carry out.
REQ-025 Minimum throughput SHALL be one instruction per 2 cycles (REQ with immediate ack, HOLD with immediate step_en).
REQ-026 mem_addr SHALL be stable for the entire duration of mem_req.
REQ-027 Timeout counter SHALL clear on entry to REQ and increment each REQ cycle without mem_ack.
REQ-028 When the counter reaches TIMEOUT without mem_ack, the FSM SHALL go to FAULT; fault=1 and mem_req=0 from the next cycle.
REQ-029 mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL win: FSM goes to HOLD, no fault.
REQ-030 FAULT SHALL be exited only by rst; mem_ack in FAULT SHALL be ignored.
REQ-031 mem_ack outside REQ SHALL be ignored.

Reset
REQ-032 rst SHALL load pc=RESET_PC, instr=16'h0000, state=IDLE and counter=0, and SHALL drive instr_valid=0, mem_req=0 and fault=0 from the next cycle.
REQ-033 rst SHALL override every state, including mid-request and FAULT, and SHALL discard any in-flight fetch.

Structure
REQ-034 The FSM state encoding and RESET_PC/TIMEOUT defaults SHALL live in the shared CPU package.
REQ-035 The block SHALL be one module with no sub-modules; the timeout counter SHALL be inline.

Verification
REQ-036 Reset, then mem_ack on the first REQ cycle with mem_data=16'h1234 -> HOLD, instr=16'h1234, instr_valid=1, pc=16'h0000.
REQ-037 HOLD with pc=16'h0005, step_en=1, incr=1 -> next mem_addr=16'h0006; with jmp=1, target=16'h0040 instead -> mem_addr=16'h0040.
REQ-038 pc=16'hFFFF, incr+step_en -> pc=16'h0000.
REQ-039 TIMEOUT=8, no mem_ack -> fault=1 after the 8th REQ cycle, mem_req=0; with mem_ack on the 8th cycle -> HOLD, fault=0.
REQ-040 rst asserted mid-REQ at pc=16'h0020 -> next cycle pc=RESET_PC, mem_req=0, instr_valid=0, state IDLE.
REQ-041 jmp=1 and incr=1 with target=16'h0100 -> pc=16'h0100; step_en=0 for 5 cycles -> instr and pc unchanged.

Source files
------------

// File: rtl/fetch_pc_pkg.sv
// Shared CPU definitions for the instruction fetch stage: FSM encoding and
// reset/timeout defaults.
package fetch_pc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetchState_e;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam int          TIMEOUT_DEFAULT  = 8;

  // Jump wins over sequential advance; neither means re-fetch the same address.
  function automatic logic [15:0] nextPc(
    input logic [15:0] curPc,
    input logic        takeJmp,
    input logic        takeIncr,
    input logic [15:0] jmpTarget
  );
    if (takeJmp)       return jmpTarget;
    else if (takeIncr) return curPc + 16'd1;
    else               return curPc;
  endfunction

endpackage

// File: rtl/fetch_pc_if.sv
// Fetch-stage bus: jump control, memory request/response and the held
// instruction presented to execute.
interface fetch_pc_if;

  logic        jmp;
  logic        incr;
  logic [15:0] target;
  logic        step_en;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] pc;
  logic [15:0] instr;
  logic        instr_valid;
  logic        fault;

  modport master (
    output jmp, incr, target, step_en, mem_ack, mem_data,
    input  mem_req, mem_addr, pc, instr, instr_valid, fault
  );

  modport slave (
    input  jmp, incr, target, step_en, mem_ack, mem_data,
    output mem_req, mem_addr, pc, instr, instr_valid, fault
  );

endinterface

// File: rtl/fetch_pc.sv
// Program counter and instruction fetch FSM: requests the word at pc, holds it
// for execute, then advances, jumps or re-fetches; a stalled request faults.
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  fetch_pc_if.slave bus
);

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  fetchState_e state;
  logic [15:0] pcReg;
  logic [15:0] instrReg;
  logic [7:0]  waitCnt;
  logic        memReq;
  logic        instrValid;
  logic        faultReg;

  // NOTE: every state element uses non-blocking assignment so all registers
  // see the pre-edge values of each other, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pcReg      <= RESET_PC;
      instrReg   <= 16'h0000;
      waitCnt    <= 8'd0;
      memReq     <= 1'b0;
      instrValid <= 1'b0;
      faultReg   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state   <= REQ;
          memReq  <= 1'b1;
          waitCnt <= 8'd0;
        end
        REQ: begin
          // An ack on the last allowed cycle still completes the fetch.
          if (bus.mem_ack) begin
            state      <= HOLD;
            instrReg   <= bus.mem_data;
            memReq     <= 1'b0;
            instrValid <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 8'd1;
            if (waitCnt == LAST_WAIT) begin
              state    <= FAULT;
              memReq   <= 1'b0;
              faultReg <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.step_en) begin
            state      <= REQ;
            pcReg      <= nextPc(pcReg, bus.jmp, bus.incr, bus.target);
            memReq     <= 1'b1;
            instrValid <= 1'b0;
            waitCnt    <= 8'd0;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // pc only changes on the HOLD->REQ edge, so the address is stable while requesting.
  assign bus.pc          = pcReg;
  assign bus.mem_addr    = pcReg;
  assign bus.instr       = instrReg;
  assign bus.mem_req     = memReq;
  assign bus.instr_valid = instrValid;
  assign bus.fault       = faultReg;

endmodule
